dmem_dp_param: RTL
==================

DMEM_DP_PARAM -- requirements
Module: dmem_dp_param

Interface
REQ-001 SHALL have parameter DATA_W, default 32, giving the data word width in bits; it must be a multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 8, giving the word-address width.
REQ-003 SHALL have parameter DEPTH, default 256, giving the number of words; DEPTH <= 2**ADDR_W.
REQ-004 SHALL have parameter RD_LAT, default 1, giving the read latency in cycles; legal range 1..3.
REQ-005 SHALL have one clock and an asynchronous, active-high reset: clk_i  input  1  clock, with all state on its rising edge.
REQ-006 SHALL have reset_i  input  1  asynchronous, active-high reset.
REQ-007 SHALL have csb_write_i  input  1  active-low write-port select.
REQ-008 SHALL have wmask_i  input  DATA_W/8  byte write enables.
REQ-009 SHALL have waddr_i  input  ADDR_W  write word address.
REQ-010 SHALL have din_i  input  DATA_W  write data.
REQ-011 SHALL have csb_read_i  input  1  active-low read-port select.
REQ-012 SHALL have raddr_i  input  ADDR_W  read word address.
REQ-013 SHALL have dout_o  output  DATA_W  read data.
REQ-014 SHALL have rvalid_o  output  1  one-cycle pulse marking valid dout_o.
REQ-015 SHALL have collision_o  output  1  one-cycle pulse for a same-address read and write.
REQ-016 SHALL have oob_o  output  1  one-cycle pulse for an access at address >= DEPTH.

Function
REQ-017 SHALL write byte b of din_i to mem[waddr_i] on a rising edge where csb_write_i=0 and wmask_i[b]=1; bytes whose mask bit is 0 are unchanged.
REQ-018 SHALL capture raddr_i on a rising edge where csb_read_i=0, then drive dout_o with that word and assert rvalid_o exactly RD_LAT cycles later.
REQ-019 SHALL pipeline reads fully: one new read may be accepted every cycle, and results return in issue order.
REQ-020 SHALL hold dout_o at its last value while rvalid_o=0.
REQ-021 SHALL ignore a write with waddr_i >= DEPTH (memory unchanged) and pulse oob_o in the following cycle.
REQ-022 SHALL, for a read with raddr_i >= DEPTH, return all-zero data with normal rvalid_o timing and pulse oob_o in the following cycle.
REQ-023 SHALL, when both ports select the same in-range address on one edge, pulse collision_o in the following cycle; the data returned is set by REQ-030/REQ-031.
REQ-024 SHALL return new data for a read issued on any edge after the write edge, for RD_LAT >= 1.
REQ-025 SHALL not change memory on a write with wmask_i=0; it is still checked for oob_o.

Reset
REQ-026 SHALL, while reset_i=1, force dout_o=0, rvalid_o=0, collision_o=0 and oob_o=0, and clear the read pipeline asynchronously.
REQ-027 SHALL drop reads in flight when reset asserts; no rvalid_o pulse follows for them after reset releases.
REQ-028 SHALL leave memory contents unchanged by reset, and SHALL ignore writes while reset_i=1.
REQ-029 SHALL accept a new access on the first rising edge after reset_i deasserts.

Configuration
REQ-030 SHALL, with DMEM_BYPASS_EN defined, return the merged word for a same-edge same-address read and write: new bytes where the mask is set, old bytes elsewhere.
REQ-031 SHALL, without DMEM_BYPASS_EN, return the pre-write word in that case; collision_o behaves identically in both builds.

Verification
REQ-032 SHALL cover: write 0xDEADBEEF to addr 5 with mask 0xF, read addr 5 -> dout_o=0xDEADBEEF with rvalid_o exactly RD_LAT cycles after the read edge.
REQ-033 SHALL cover: addr 5 = 0xDEADBEEF, write 0x11223344 with mask 0x3, read -> 0xDEAD3344.
REQ-034 SHALL cover: reads of addr 1, 2, 3 on back-to-back cycles -> three consecutive rvalid_o pulses carrying data in that order, for RD_LAT = 1, 2 and 3.
REQ-035 SHALL cover: same-edge write 0xAAAAAAAA mask 0x5 and read of addr 7 (old value 0x0) -> 0x00AA00AA with DMEM_BYPASS_EN and 0x0 without, and collision_o=1 in both builds.
REQ-036 SHALL cover: DEPTH=200, write to addr 250 -> oob_o pulse and no memory change; read of addr 250 -> dout_o=0 with oob_o pulse.
REQ-037 SHALL cover: RD_LAT=3 read issued, reset asserted one cycle later -> outputs 0 at once, no rvalid_o after release, and memory still holds its pre-reset values.

Source files
------------

// File: rtl/dmem_dp_param.sv
// dmem_dp_param: one-write/one-read port data memory with byte write
// enables, a fully pipelined read path of RD_LAT cycles, and one-cycle
// status pulses for same-address collisions and out-of-range accesses.
// Optional build macro: DMEM_BYPASS_EN -- a read that hits the address
// written on the same edge returns the merged (post-write) word instead
// of the pre-write word.
module dmem_dp_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 1
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                csb_write_i,
  input  logic [DATA_W/8-1:0] wmask_i,
  input  logic [ADDR_W-1:0]   waddr_i,
  input  logic [DATA_W-1:0]   din_i,
  input  logic                csb_read_i,
  input  logic [ADDR_W-1:0]   raddr_i,
  output logic [DATA_W-1:0]   dout_o,
  output logic                rvalid_o,
  output logic                collision_o,
  output logic                oob_o
);

  localparam int NB = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  // Byte-wise merge: new bytes where mask is set, old bytes elsewhere.
  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [NB-1:0]     mask
  );
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int b = 0; b < NB; b++) begin
      if (mask[b]) begin
        res[b*8 +: 8] = new_w[b*8 +: 8];
      end else begin
        res[b*8 +: 8] = old_w[b*8 +: 8];
      end
    end
    return res;
  endfunction

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              wr_sel_s, rd_sel_s;
  logic              wr_in_range_s, rd_in_range_s;
  logic              wr_en_s, same_addr_s;
  logic [IDX_W-1:0]  widx_s, ridx_s;
  logic [DATA_W-1:0] rd_old_s, wr_merged_s, rd_word_s;

  logic              collision_d, collision_q;
  logic              oob_d, oob_q;
  logic [DATA_W-1:0] data_d [RD_LAT];
  logic [DATA_W-1:0] data_q [RD_LAT];
  logic [RD_LAT-1:0] vld_d, vld_q;

  // Decode port selects, range checks and the word seen by each port.
  always_comb begin
    wr_sel_s      = ~csb_write_i;
    rd_sel_s      = ~csb_read_i;
    wr_in_range_s = ({1'b0, waddr_i} < DEPTH_C);
    rd_in_range_s = ({1'b0, raddr_i} < DEPTH_C);
    widx_s        = waddr_i[IDX_W-1:0];
    ridx_s        = raddr_i[IDX_W-1:0];
    same_addr_s   = wr_sel_s & rd_sel_s & rd_in_range_s & (waddr_i == raddr_i);
    wr_en_s       = wr_sel_s & wr_in_range_s & ~reset_i;
    rd_old_s      = mem_q[ridx_s];
    wr_merged_s   = merge_bytes(mem_q[widx_s], din_i, wmask_i);
`ifdef DMEM_BYPASS_EN
    // Same address means wr_merged_s is the post-write image of this word.
    if (same_addr_s) begin
      rd_word_s = wr_merged_s;
    end else begin
      rd_word_s = rd_old_s;
    end
`else
    rd_word_s = rd_old_s;
`endif
    collision_d = same_addr_s;
    oob_d       = (wr_sel_s & ~wr_in_range_s) | (rd_sel_s & ~rd_in_range_s);
  end

  // Memory array write port; contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_s) begin
      mem_q[widx_s] <= wr_merged_s;
    end
  end

  // Read pipeline next state: each stage only loads when its input is valid,
  // so the last stage (dout_o) holds its value between pulses.
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    vld_d[0] = rd_sel_s;
    if (rd_sel_s) begin
      if (rd_in_range_s) begin
        data_d[0] = rd_word_s;
      end else begin
        data_d[0] = {DATA_W{1'b0}};
      end
    end else begin
      data_d[0] = data_q[0];
    end
    for (int k = 1; k < RD_LAT; k++) begin
      vld_d[k] = vld_q[k-1];
      if (vld_q[k-1]) begin
        data_d[k] = data_q[k-1];
      end else begin
        data_d[k] = data_q[k];
      end
    end
  end

  // Read pipeline and status pulse registers; reset drops reads in flight.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int k = 0; k < RD_LAT; k++) begin
        data_q[k] <= {DATA_W{1'b0}};
      end
      vld_q       <= {RD_LAT{1'b0}};
      collision_q <= 1'b0;
      oob_q       <= 1'b0;
    end else begin
      data_q      <= data_d;
      vld_q       <= vld_d;
      collision_q <= collision_d;
      oob_q       <= oob_d;
    end
  end

  assign dout_o      = data_q[RD_LAT-1];
  assign rvalid_o    = vld_q[RD_LAT-1];
  assign collision_o = collision_q;
  assign oob_o       = oob_q;

endmodule
